bus_selftest_seq: RTL and testbench
===================================

# bus_selftest_seq

Parametrised on-chip stimulus sequencer for the serial-bus system. It replaces manual button and switch operation with a programmable sequence: N configuration presses, then a write, a read, or a write-then-read issued from a selected master. It sits between board I/O and the top-level bus controls and drives the same active-low button and switch signals the bus logic already expects. It watches each master's busy line and reports completion or timeout, so the bus can be soak-tested on hardware without a host.

## Interface
- NUM_MASTERS, 2, number of master channels driven (>=1)
- SW_WIDTH, 12, width of the configuration switch word
- CFG_STEPS, 7, configuration presses per sequence (>=1)
- PRESS_CYCLES, 10, cycles a button is held low (>=1)
- GAP_CYCLES, 10, release cycles after each press (>=1)
- TIMEOUT_CYCLES, 20000, cycle limit for each busy-rise and busy-fall wait
- clock  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  start request, sampled only in IDLE
- master_sel  in  $clog2(NUM_MASTERS) (min 1)  target master, latched at start
- cfg_value  in  SW_WIDTH  configuration word, latched at start
- op_mode  in  2  0=write, 1=read, 2=write then read, 3=reserved; latched at start
- skip_cfg  in  1  skip the configuration phase; latched at start
- m_busy  in  NUM_MASTERS  per-master busy, same clock domain, no synchroniser
- cfg_button_n  out  1  configuration button, active-low
- button_n  out  NUM_MASTERS  per-master operation buttons, active-low
- mode_switch  out  1  0=configuration, 1=operation
- rw_switch  out  NUM_MASTERS  per-master direction, 0=write, 1=read
- switch_array  out  SW_WIDTH  configuration word to the bus
- seq_busy  out  1  high from the cycle after start until DONE inclusive
- done  out  1  one-cycle completion pulse
- timeout  out  1  valid with done: a wait exceeded TIMEOUT_CYCLES
- err  out  1  valid with done: illegal master_sel or op_mode=3

## Operation
- States: IDLE, CFG_PRESS, CFG_GAP, OP_PRESS, WAIT_RISE, WAIT_FALL, OP_GAP, DONE.
- IDLE: all outputs at their reset values. If start=1, latch the inputs and move to the next state.
  - master_sel >= NUM_MASTERS or op_mode=3 → DONE with err=1.
  - Otherwise skip_cfg=0 → CFG_PRESS; skip_cfg=1 → OP_PRESS.
- CFG_PRESS: mode_switch=0, switch_array=cfg_value, cfg_button_n=0 for PRESS_CYCLES cycles, then CFG_GAP.
- CFG_GAP: cfg_button_n=1 for GAP_CYCLES cycles. Increment the step counter. If steps < CFG_STEPS → CFG_PRESS, else → OP_PRESS.
- OP_PRESS: mode_switch=1, rw_switch[m]=current direction, button_n[m]=0 for PRESS_CYCLES cycles, then WAIT_RISE.
  - Current direction is 0 for op_mode 0, 1 for op_mode 1, and 0 then 1 for op_mode 2.
  - Only bit m changes. All other button_n bits stay 1 and all other rw_switch bits stay 0.
- WAIT_RISE: leave on the first cycle m_busy[m]=1 → WAIT_FALL. If m_busy[m] was already high on entry, exit immediately.
- WAIT_FALL: leave on the first cycle m_busy[m]=0.
  - op_mode=2 and first phase → OP_GAP. OP_GAP holds GAP_CYCLES, then OP_PRESS with direction 1.
  - Otherwise → DONE.
- WAIT_RISE and WAIT_FALL each run their own counter. Reaching TIMEOUT_CYCLES → DONE with timeout=1. mode_switch and rw_switch keep their values.
- DONE: done=1 for one cycle, then IDLE, where timeout and err clear.
- A start during any non-IDLE state is ignored. Changes to the latched inputs during a sequence are ignored.
- rst mid-sequence: all outputs return to reset values on the same edge and no done pulse is produced.

## Timing
- Reset values:
  - cfg_button_n=1, button_n=all 1s, mode_switch=1, rw_switch=0, switch_array=0.
  - seq_busy=0, done=0, timeout=0, err=0.
- All outputs are registered.
- Start sampled at cycle 0 → first press output at cycle 1.
- Configuration phase length: CFG_STEPS·(PRESS_CYCLES+GAP_CYCLES) cycles exactly.
- Busy sampling: WAIT_RISE samples m_busy from the first cycle after the press is released. m_busy seen high at cycle t → WAIT_FALL at t+1. Seen low at cycle u → done at u+1 (or OP_GAP at u+1).
- err path: start at cycle 0 → done=1, err=1 at cycle 1.
- Counter widths: $clog2(max(PRESS_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)+1) bits; the step counter is $clog2(CFG_STEPS+1) bits. No wrap-around in legal operation.

## Test plan
Bench parameters for all scenarios: NUM_MASTERS=2, CFG_STEPS=7, PRESS_CYCLES=10, GAP_CYCLES=10, TIMEOUT_CYCLES=100.

- Reset: hold rst for 3 cycles → all outputs at their reset values; start asserted during rst is ignored.
- Write with configuration: start at cycle 0 with cfg_value=129, master_sel=0, op_mode=0; m_busy[0] high cycles 155–204 →
  - cfg_button_n low at cycles 1–10, 21–30, …, 121–130, with switch_array=129 and mode_switch=0;
  - button_n[0] low at 141–150 with rw_switch[0]=0;
  - done=1 at 206 with timeout=0;
  - button_n[1] stays 1 throughout.
- Write then read: skip_cfg=1, master_sel=1, op_mode=2; busy model responds to each press →
  - two button_n[1] presses separated by at least 10 released cycles;
  - rw_switch[1]=0 for the first press and 1 for the second;
  - exactly one done pulse.
- Timeout: op_mode=1 with m_busy tied 0 → done=1 and timeout=1 exactly 100 cycles after WAIT_RISE entry. Repeat with m_busy stuck 1 → timeout raised from WAIT_FALL.
- Errors and ignored starts:
  - master_sel=2 or op_mode=3 → done=1 and err=1 at cycle 1, with no button activity;
  - a second start mid-sequence produces no restart.
- Reset mid-sequence: rst asserted at cycle 60 → all outputs at reset values at cycle 61; no done pulse; a new start afterwards runs normally.

Source files
------------

// File: rtl/bus_selftest_seq.sv
// -----------------------------------------------------------------------------
// bus_selftest_seq
//
// On-chip stimulus sequencer for the serial-bus system. It replaces manual
// button and switch operation with a programmable sequence. The sequence is
// CFG_STEPS configuration presses (optional), then a write, a read, or a
// write-then-read issued from one selected master. It watches that master's
// busy line and reports completion or timeout.
//
// Ports
//   clock_i         system clock
//   rst_i           synchronous reset, active-high
//   start_i         start request, sampled only in IDLE
//   master_sel_i    target master, latched at start
//   cfg_value_i     configuration word, latched at start
//   op_mode_i       0=write, 1=read, 2=write then read, 3=reserved
//   skip_cfg_i      skip the configuration phase, latched at start
//   m_busy_i        per-master busy (same clock domain)
//   cfg_button_n_o  configuration button, active-low
//   button_n_o      per-master operation buttons, active-low
//   mode_switch_o   0=configuration, 1=operation
//   rw_switch_o     per-master direction, 0=write, 1=read
//   switch_array_o  configuration word to the bus
//   seq_busy_o      high from the cycle after start until DONE inclusive
//   done_o          one-cycle completion pulse
//   timeout_o       valid with done_o: a busy wait ran out
//   err_o           valid with done_o: illegal master_sel or op_mode=3
//   state_o         current FSM state (debug)
//
// Handshake: start_i is a plain level request. It is honoured only on a clock
// edge where the FSM is in IDLE; at other times it is ignored. There is no
// ready/ack. Completion is reported by a single done_o pulse, and
// timeout_o/err_o are qualified by that pulse.
// -----------------------------------------------------------------------------
module bus_selftest_seq #(
   parameter int NUM_MASTERS    = 2,
   parameter int SW_WIDTH       = 12,
   parameter int CFG_STEPS      = 7,
   parameter int PRESS_CYCLES   = 10,
   parameter int GAP_CYCLES     = 10,
   parameter int TIMEOUT_CYCLES = 20000,
   localparam int MSEL_W        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                   clock_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [MSEL_W-1:0]      master_sel_i,
   input  logic [SW_WIDTH-1:0]    cfg_value_i,
   input  logic [1:0]             op_mode_i,
   input  logic                   skip_cfg_i,
   input  logic [NUM_MASTERS-1:0] m_busy_i,
   output logic                   cfg_button_n_o,
   output logic [NUM_MASTERS-1:0] button_n_o,
   output logic                   mode_switch_o,
   output logic [NUM_MASTERS-1:0] rw_switch_o,
   output logic [SW_WIDTH-1:0]    switch_array_o,
   output logic                   seq_busy_o,
   output logic                   done_o,
   output logic                   timeout_o,
   output logic                   err_o,
   output logic [2:0]             state_o
);

   localparam int MAX_PG = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
   localparam int MAX_C  = (MAX_PG > TIMEOUT_CYCLES) ? MAX_PG : TIMEOUT_CYCLES;
   localparam int CNT_W  = $clog2(MAX_C + 1);
   localparam int STEP_W = $clog2(CFG_STEPS + 1);

   localparam logic [CNT_W-1:0]  PRESS_LAST = CNT_W'(PRESS_CYCLES - 1);
   localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(CFG_STEPS - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CFG_PRESS = 3'd1,
      CFG_GAP   = 3'd2,
      OP_PRESS  = 3'd3,
      WAIT_RISE = 3'd4,
      WAIT_FALL = 3'd5,
      OP_GAP    = 3'd6,
      DONE      = 3'd7
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [STEP_W-1:0]   step_q;
   logic [MSEL_W-1:0]   m_q;
   logic [1:0]          op_q;
   logic                second_q;   // set once the write half of op_mode=2 has finished

   logic                   cfg_button_n_q;
   logic [NUM_MASTERS-1:0] button_n_q;
   logic                   mode_switch_q;
   logic [NUM_MASTERS-1:0] rw_switch_q;
   logic [SW_WIDTH-1:0]    switch_array_q;
   logic                   seq_busy_q;
   logic                   done_q;
   logic                   timeout_q;
   logic                   err_q;

   logic start_illegal;
   logic press_dir;
   logic busy_sel;

   assign start_illegal = (int'(master_sel_i) >= NUM_MASTERS) || (op_mode_i == 2'd3);
   // Direction of the next operation press: read for op_mode=1, and read for
   // the second half of a write-then-read.
   assign press_dir     = (op_q == 2'd1) || second_q;
   assign busy_sel      = m_busy_i[m_q];

   always_ff @(posedge clock_i) begin
      if (rst_i) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         step_q         <= '0;
         m_q            <= '0;
         op_q           <= '0;
         second_q       <= 1'b0;
         cfg_button_n_q <= 1'b1;
         button_n_q     <= '1;
         mode_switch_q  <= 1'b1;
         rw_switch_q    <= '0;
         switch_array_q <= '0;
         seq_busy_q     <= 1'b0;
         done_q         <= 1'b0;
         timeout_q      <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  m_q        <= master_sel_i;
                  op_q       <= op_mode_i;
                  second_q   <= 1'b0;
                  cnt_q      <= '0;
                  step_q     <= '0;
                  seq_busy_q <= 1'b1;
                  if (start_illegal) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                  end else if (!skip_cfg_i) begin
                     state_q        <= CFG_PRESS;
                     mode_switch_q  <= 1'b0;
                     switch_array_q <= cfg_value_i;
                     cfg_button_n_q <= 1'b0;
                  end else begin
                     state_q                   <= OP_PRESS;
                     mode_switch_q             <= 1'b1;
                     button_n_q[master_sel_i]  <= 1'b0;
                     rw_switch_q[master_sel_i] <= (op_mode_i == 2'd1);
                  end
               end
            end

            CFG_PRESS: begin
               if (cnt_q == PRESS_LAST) begin
                  cnt_q          <= '0;
                  cfg_button_n_q <= 1'b1;
                  state_q        <= CFG_GAP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            CFG_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q  <= '0;
                  step_q <= step_q + STEP_W'(1);
                  if (step_q != STEP_LAST) begin
                     state_q        <= CFG_PRESS;
                     cfg_button_n_q <= 1'b0;
                  end else begin
                     state_q          <= OP_PRESS;
                     mode_switch_q    <= 1'b1;
                     button_n_q[m_q]  <= 1'b0;
                     rw_switch_q[m_q] <= press_dir;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            OP_PRESS: begin
               if (cnt_q == PRESS_LAST) begin
                  cnt_q           <= '0;
                  button_n_q[m_q] <= 1'b1;
                  state_q         <= WAIT_RISE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            WAIT_RISE: begin
               if (busy_sel) begin
                  cnt_q   <= '0;
                  state_q <= WAIT_FALL;
               end else if (cnt_q == TO_LAST) begin
                  cnt_q     <= '0;
                  state_q   <= DONE;
                  done_q    <= 1'b1;
                  timeout_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            WAIT_FALL: begin
               if (!busy_sel) begin
                  cnt_q <= '0;
                  if ((op_q == 2'd2) && !second_q) begin
                     second_q <= 1'b1;
                     state_q  <= OP_GAP;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end else if (cnt_q == TO_LAST) begin
                  cnt_q     <= '0;
                  state_q   <= DONE;
                  done_q    <= 1'b1;
                  timeout_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            OP_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q            <= '0;
                  state_q          <= OP_PRESS;
                  button_n_q[m_q]  <= 1'b0;
                  rw_switch_q[m_q] <= press_dir;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            DONE: begin
               // Return every output to its idle value while leaving.
               state_q        <= IDLE;
               cnt_q          <= '0;
               cfg_button_n_q <= 1'b1;
               button_n_q     <= '1;
               mode_switch_q  <= 1'b1;
               rw_switch_q    <= '0;
               switch_array_q <= '0;
               seq_busy_q     <= 1'b0;
               done_q         <= 1'b0;
               timeout_q      <= 1'b0;
               err_q          <= 1'b0;
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign cfg_button_n_o = cfg_button_n_q;
   assign button_n_o     = button_n_q;
   assign mode_switch_o  = mode_switch_q;
   assign rw_switch_o    = rw_switch_q;
   assign switch_array_o = switch_array_q;
   assign seq_busy_o     = seq_busy_q;
   assign done_o         = done_q;
   assign timeout_o      = timeout_q;
   assign err_o          = err_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_bus_selftest_seq.sv
// -----------------------------------------------------------------------------
// tb_bus_selftest_seq
//
// Directed bench for bus_selftest_seq. Each scenario starts a sequence at
// cycle 0 and compares the packed output word at every following cycle with
// a hand-derived expected word. A second instance with three masters covers
// the out-of-range master_sel case, which a 1-bit select cannot express.
// -----------------------------------------------------------------------------
module tb_bus_selftest_seq;

   localparam int SW_W = 12;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT (2 masters) ----------------
   logic            start_i = 1'b0;
   logic [0:0]      master_sel = '0;
   logic [SW_W-1:0] cfg_value = '0;
   logic [1:0]      op_mode = '0;
   logic            skip_cfg = 1'b0;
   logic [1:0]      m_busy = '0;
   logic            cfg_button_n;
   logic [1:0]      button_n;
   logic            mode_switch;
   logic [1:0]      rw_switch;
   logic [SW_W-1:0] switch_array;
   logic            seq_busy, done, timeout, err;
   logic [2:0]      state;

   bus_selftest_seq #(
      .NUM_MASTERS(2), .SW_WIDTH(SW_W), .CFG_STEPS(7),
      .PRESS_CYCLES(10), .GAP_CYCLES(10), .TIMEOUT_CYCLES(100)
   ) u_dut (
      .clock_i(clk), .rst_i(rst), .start_i(start_i),
      .master_sel_i(master_sel), .cfg_value_i(cfg_value),
      .op_mode_i(op_mode), .skip_cfg_i(skip_cfg), .m_busy_i(m_busy),
      .cfg_button_n_o(cfg_button_n), .button_n_o(button_n),
      .mode_switch_o(mode_switch), .rw_switch_o(rw_switch),
      .switch_array_o(switch_array), .seq_busy_o(seq_busy),
      .done_o(done), .timeout_o(timeout), .err_o(err), .state_o(state)
   );

   // ---------------- DUT (3 masters, out-of-range select) ----------------
   logic            start3 = 1'b0;
   logic [1:0]      msel3 = '0;
   logic [2:0]      busy3 = '0;
   logic            cfg_bn3, mode3, sb3, done3, to3, err3;
   logic [2:0]      bn3, rw3, state3;
   logic [SW_W-1:0] sw3;

   bus_selftest_seq #(
      .NUM_MASTERS(3), .SW_WIDTH(SW_W), .CFG_STEPS(7),
      .PRESS_CYCLES(10), .GAP_CYCLES(10), .TIMEOUT_CYCLES(100)
   ) u_dut3 (
      .clock_i(clk), .rst_i(rst), .start_i(start3),
      .master_sel_i(msel3), .cfg_value_i(12'd0),
      .op_mode_i(2'd0), .skip_cfg_i(1'b0), .m_busy_i(busy3),
      .cfg_button_n_o(cfg_bn3), .button_n_o(bn3),
      .mode_switch_o(mode3), .rw_switch_o(rw3),
      .switch_array_o(sw3), .seq_busy_o(sb3),
      .done_o(done3), .timeout_o(to3), .err_o(err3), .state_o(state3)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   // Packed order: {cfg_bn, button_n[1:0], mode, rw[1:0], sw[11:0], seq_busy, done, timeout, err}
   localparam logic [21:0] RESET_VEC = {1'b1, 2'b11, 1'b1, 2'b00, 12'd0, 4'b0000};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [21:0] obs_vec();
      return {cfg_button_n, button_n, mode_switch, rw_switch, switch_array,
              seq_busy, done, timeout, err};
   endfunction

   // Hand-derived expected outputs at cycle c (start sampled at cycle 0).
   //  s0: cfg=129, master 0, write, busy[0] high 155..204 -> done at 206
   //  s1: skip cfg, master 1, write-then-read, busy[1] 13..17 and 40..44
   //      -> presses 1..10 (write) and 29..38 (read), done at 46
   //  s2: skip cfg, master 0, read, busy 0 -> timeout from WAIT_RISE at 111
   //  s3: same with busy stuck 1 -> timeout from WAIT_FALL at 112
   //  s4: as s0, reset sampled at cycle 60 -> reset values from cycle 61
   //  s5: op_mode=3 -> done+err at cycle 1
   function automatic logic [21:0] exp_vec(input int s, input int c);
      logic cfg_bn, mode, sb, dn, to, er;
      logic [1:0] bn, rw;
      logic [SW_W-1:0] sw;
      int t;
      cfg_bn = 1'b1; bn = 2'b11; rw = 2'b00; mode = 1'b1; sw = '0;
      sb = 1'b0; dn = 1'b0; to = 1'b0; er = 1'b0;
      t = (s == 2) ? 111 : 112;
      case (s)
         0, 4: begin
            if (s == 0 || c <= 60) begin
               if (c <= 140) begin
                  mode   = 1'b0;
                  cfg_bn = ((c - 1) % 20) >= 10;
               end
               if (c >= 141 && c <= 150) bn[0] = 1'b0;
               if (c <= 206) begin
                  sw = 12'd129;
                  sb = 1'b1;
               end
               dn = (c == 206);
            end
         end
         1: begin
            if (c <= 10 || (c >= 29 && c <= 38)) bn[1] = 1'b0;
            if (c >= 29 && c <= 46) rw[1] = 1'b1;
            sb = (c <= 46);
            dn = (c == 46);
         end
         2, 3: begin
            if (c <= 10) bn[0] = 1'b0;
            if (c <= t) begin
               rw[0] = 1'b1;
               sb    = 1'b1;
            end
            dn = (c == t);
            to = (c == t);
         end
         5: begin
            if (c == 1) begin
               sb = 1'b1; dn = 1'b1; er = 1'b1;
            end
         end
         default: ;
      endcase
      return {cfg_bn, bn, mode, rw, sw, sb, dn, to, er};
   endfunction

   function automatic logic [1:0] busy_model(input int s, input int c);
      logic [1:0] b;
      b = 2'b00;
      case (s)
         0: b[0] = (c >= 155 && c <= 204);
         1: b[1] = (c >= 13 && c <= 17) || (c >= 40 && c <= 44);
         3: b[0] = 1'b1;
         default: ;
      endcase
      return b;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_scenario(input int s, input logic [0:0] msel,
                               input logic [SW_W-1:0] cfg, input logic [1:0] op,
                               input logic skip, input int ncyc);
      // cycle 0: present the request
      master_sel = msel;
      cfg_value  = cfg;
      op_mode    = op;
      skip_cfg   = skip;
      start_i    = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         tick();
         start_i = 1'b0;
         // mid-sequence start with different inputs must be ignored
         if (s == 1 && c == 20) begin
            start_i    = 1'b1;
            master_sel = 1'b0;
            op_mode    = 2'd0;
            skip_cfg   = 1'b0;
            cfg_value  = 12'hFFF;
         end
         if (s == 4 && c == 60) rst = 1'b1;
         if (s == 4 && c == 61) rst = 1'b0;
         m_busy = busy_model(s, c);
         check_eq($sformatf("s%0d_c%0d", s, c), 32'(obs_vec()), 32'(exp_vec(s, c)));
      end
      start_i = 1'b0;
      m_busy  = '0;
      tick();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      // reset with start asserted: must be ignored
      rst     = 1'b1;
      start_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq($sformatf("rst_hold%0d", i), 32'(obs_vec()), 32'(RESET_VEC));
      end
      rst     = 1'b0;
      start_i = 1'b0;
      tick();
      check_eq("rst_after", 32'(obs_vec()), 32'(RESET_VEC));
      check_eq("rst_state", 32'(state), 32'(3'd0));
      check_eq("rst_dut3", 32'({cfg_bn3, bn3, mode3, rw3, sb3, done3, to3, err3}),
               32'({1'b1, 3'b111, 1'b1, 3'b000, 4'b0000}));
      tick();
      check_eq("rst_idle", 32'(obs_vec()), 32'(RESET_VEC));

      run_scenario(0, 1'b0, 12'd129, 2'd0, 1'b0, 210);
      run_scenario(1, 1'b1, 12'd0,   2'd2, 1'b1, 50);
      run_scenario(2, 1'b0, 12'd0,   2'd1, 1'b1, 114);
      run_scenario(3, 1'b0, 12'd0,   2'd1, 1'b1, 115);
      run_scenario(5, 1'b0, 12'd0,   2'd3, 1'b0, 4);

      // out-of-range master select on the 3-master instance
      msel3  = 2'd3;
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      check_eq("msel_err_c1", 32'({bn3, sb3, done3, to3, err3}),
               32'({3'b111, 1'b1, 1'b1, 1'b0, 1'b1}));
      tick();
      check_eq("msel_err_c2", 32'({bn3, sb3, done3, to3, err3}),
               32'({3'b111, 1'b0, 1'b0, 1'b0, 1'b0}));

      // reset mid-sequence, then a normal run afterwards
      run_scenario(4, 1'b0, 12'd129, 2'd0, 1'b0, 70);
      run_scenario(0, 1'b0, 12'd129, 2'd0, 1'b0, 210);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
